// File: rtl/tx_burst_ctrl.sv
// Framed serial burst transmitter: preamble, payload and gap frames until MAX_BITS payload bits are sent.
// Optional feature macro TX_PRBS_EN: PRBS-7 payload instead of the fixed PATTERN byte.
module tx_burst_ctrl #(
  parameter logic [31:0] MAX_BITS     = 32'd80000000,
  parameter logic [31:0] FRAME_BITS   = 32'd1024,
  parameter int unsigned PREAMBLE_LEN = 16,
  parameter int unsigned GAP_LEN      = 8,
  parameter logic [7:0]  PATTERN      = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_en,
  input  logic        abort,
  output logic        tx_bit_data,
  output logic        tx_active,
  output logic        frame_start,
  output logic        done,
  output logic [31:0] bit_count,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    PAYLOAD  = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [31:0] PRE_LAST   = 32'(PREAMBLE_LEN) - 32'd1;
  localparam logic [31:0] GAP_LAST   = 32'(GAP_LEN) - 32'd1;
  localparam logic [31:0] FRAME_LAST = FRAME_BITS - 32'd1;

  state_t      state_r, state_s;
  logic [31:0] cnt_r, cnt_s, cnt_inc_s;
  logic [31:0] bit_count_r, bit_count_s;
  logic [15:0] frame_count_r, frame_count_s;
  logic        tx_r, tx_s;
  logic        frame_start_r, frame_start_s;
  logic        tx_active_r, tx_active_s;
  logic        done_r, done_s;
  logic        sync1_r, bit_en_s;
  logic        payload_last_s;
  logic        first_bit_s, next_bit_s;

  // Two-flop synchronizer for the asynchronous run enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r  <= 1'b0;
      bit_en_s <= 1'b0;
    end else begin
      sync1_r  <= bit_en;
      bit_en_s <= sync1_r;
    end
  end

  assign cnt_inc_s      = cnt_r + 32'd1;
  assign payload_last_s = (cnt_r == FRAME_LAST) || (bit_count_r == MAX_BITS);

`ifdef TX_PRBS_EN
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  // x^7 + x^6 + 1; the newly shifted-in bit is the transmitted bit
  function automatic logic [6:0] prbs_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  logic [6:0] lfsr_r, seed_step_s, run_step_s;

  assign seed_step_s = prbs_step(PRBS_SEED);
  assign run_step_s  = prbs_step(lfsr_r);
  assign first_bit_s = seed_step_s[0];
  assign next_bit_s  = run_step_s[0];

  // LFSR restarts from the seed on every new payload phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= PRBS_SEED;
    end else if (abort) begin
      lfsr_r <= PRBS_SEED;
    end else if ((state_r == PREAMBLE) && (state_s == PAYLOAD)) begin
      lfsr_r <= seed_step_s;
    end else if ((state_r == PAYLOAD) && (state_s == PAYLOAD)) begin
      lfsr_r <= run_step_s;
    end else begin
      lfsr_r <= lfsr_r;
    end
  end
`else
  assign first_bit_s = PATTERN[7];
  assign next_bit_s  = PATTERN[3'd7 - cnt_inc_s[2:0]];
`endif

  // Next-state and next-output logic; outputs describe the bit sent in the next cycle
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    bit_count_s   = bit_count_r;
    frame_count_s = frame_count_r;
    tx_s          = 1'b0;
    frame_start_s = 1'b0;
    if (abort) begin
      state_s       = IDLE;
      cnt_s         = 32'd0;
      bit_count_s   = 32'd0;
      frame_count_s = 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bit_en_s) begin
            if (bit_count_r == MAX_BITS) begin
              state_s = DONE;
            end else begin
              state_s       = PREAMBLE;
              cnt_s         = 32'd0;
              tx_s          = 1'b1;
              frame_start_s = 1'b1;
            end
          end else begin
            state_s = IDLE;
          end
        end
        PREAMBLE: begin
          if (!bit_en_s) begin
            state_s = IDLE;
          end else if (cnt_r == PRE_LAST) begin
            state_s     = PAYLOAD;
            cnt_s       = 32'd0;
            tx_s        = first_bit_s;
            bit_count_s = bit_count_r + 32'd1;
          end else begin
            cnt_s = cnt_inc_s;
            tx_s  = cnt_r[0];
          end
        end
        PAYLOAD: begin
          // A completed frame counts even if the enable drops on its last bit
          if (payload_last_s) begin
            frame_count_s = (frame_count_r == 16'hFFFF) ? frame_count_r : frame_count_r + 16'd1;
            if (bit_count_r == MAX_BITS) begin
              state_s = DONE;
            end else if (!bit_en_s) begin
              state_s = IDLE;
            end else begin
              state_s = GAP;
              cnt_s   = 32'd0;
            end
          end else if (!bit_en_s) begin
            state_s = IDLE;
          end else begin
            cnt_s       = cnt_inc_s;
            tx_s        = next_bit_s;
            bit_count_s = bit_count_r + 32'd1;
          end
        end
        GAP: begin
          if (!bit_en_s) begin
            state_s = IDLE;
          end else if (cnt_r == GAP_LAST) begin
            state_s       = PREAMBLE;
            cnt_s         = 32'd0;
            tx_s          = 1'b1;
            frame_start_s = 1'b1;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 32'd0;
        end
      endcase
    end
  end

  // Decode of the registered status flags from the next state
  always_comb begin
    tx_active_s = 1'b0;
    done_s      = 1'b0;
    case (state_s)
      PREAMBLE, PAYLOAD, GAP: tx_active_s = 1'b1;
      DONE:                   done_s      = 1'b1;
      default: begin
        tx_active_s = 1'b0;
        done_s      = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs are registered together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= 32'd0;
      bit_count_r   <= 32'd0;
      frame_count_r <= 16'd0;
      tx_r          <= 1'b0;
      frame_start_r <= 1'b0;
      tx_active_r   <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      bit_count_r   <= bit_count_s;
      frame_count_r <= frame_count_s;
      tx_r          <= tx_s;
      frame_start_r <= frame_start_s;
      tx_active_r   <= tx_active_s;
      done_r        <= done_s;
    end
  end

  assign tx_bit_data = tx_r;
  assign tx_active   = tx_active_r;
  assign frame_start = frame_start_r;
  assign done        = done_r;
  assign bit_count   = bit_count_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_tx_burst_ctrl.sv
// Self-checking bench for tx_burst_ctrl: frame-template reference model plus directed and random scenarios.
module tb_tx_burst_ctrl;

  localparam int MAXB = 20;
  localparam int FB   = 8;
  localparam int PL   = 4;
  localparam int GL   = 2;

  logic clk = 1'b0, rst = 1'b1, bit_en = 1'b0, abort = 1'b0, bit_en0 = 1'b0;
  logic tx_bit_data, tx_active, frame_start, done;
  logic [31:0] bit_count;
  logic [15:0] frame_count;
  logic tx0, act0, fs0, done0;
  logic [31:0] bc0;
  logic [15:0] fc0;
  logic [51:0] obs, obs0;

  int checks = 0, errors = 0;
  int m_pos, m_len, m_sent, m_frames;
  bit m_done, m_fs, q1, q2;
  bit cap [0:63];
  int ncap, nfs;

  always #5 clk = ~clk;

  tx_burst_ctrl #(.MAX_BITS(32'd20), .FRAME_BITS(32'd8), .PREAMBLE_LEN(4), .GAP_LEN(2),
                  .PATTERN(8'hAA)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .abort(abort),
    .tx_bit_data(tx_bit_data), .tx_active(tx_active), .frame_start(frame_start), .done(done),
    .bit_count(bit_count), .frame_count(frame_count));

  tx_burst_ctrl #(.MAX_BITS(32'd0), .FRAME_BITS(32'd8), .PREAMBLE_LEN(4), .GAP_LEN(2),
                  .PATTERN(8'hAA)) dut0 (
    .clk(clk), .rst(rst), .bit_en(bit_en0), .abort(1'b0),
    .tx_bit_data(tx0), .tx_active(act0), .frame_start(fs0), .done(done0),
    .bit_count(bc0), .frame_count(fc0));

  assign obs  = {tx_bit_data, tx_active, frame_start, done, frame_count, bit_count};
  assign obs0 = {tx0, act0, fs0, done0, fc0, bc0};

`ifdef TX_PRBS_EN
  bit prbs_ref [0:7];
  initial begin
    logic [6:0] s;
    s = 7'h7F;
    for (int i = 0; i < 8; i++) begin
      s = {s[5:0], s[6] ^ s[5]};
      prbs_ref[i] = s[0];
    end
  end
`endif

  // Bit at position pos of a frame whose payload holds len bits
  function automatic bit tmpl_bit(int pos, int len);
    logic [7:0] pat;
    pat = 8'hAA;
    if (pos < PL) return (pos % 2) == 0;
    if (pos < PL + len) begin
`ifdef TX_PRBS_EN
      return prbs_ref[pos - PL];
`else
      return pat[7 - ((pos - PL) % 8)];
`endif
    end
    return 1'b0;
  endfunction

  function automatic logic [51:0] model_out();
    bit tx;
    tx = (m_pos >= 0) ? tmpl_bit(m_pos, m_len) : 1'b0;
    return {tx, (m_pos >= 0), m_fs, m_done, 16'(m_frames), 32'(m_sent)};
  endfunction

  task automatic model_reset();
    m_pos = -1; m_len = 0; m_sent = 0; m_frames = 0;
    m_done = 1'b0; m_fs = 1'b0; q1 = 1'b0; q2 = 1'b0;
  endtask

  task automatic start_frame();
    m_pos = 0;
    m_len = (MAXB - m_sent < FB) ? MAXB - m_sent : FB;
    m_fs  = 1'b1;
  endtask

  task automatic model_step(input bit en_now, input bit ab);
    bit en;
    en = q2; q2 = q1; q1 = en_now;
    m_fs = 1'b0;
    if (ab) begin
      m_pos = -1; m_sent = 0; m_frames = 0; m_done = 1'b0;
    end else if (m_done) begin
      m_pos = -1;
    end else if (m_pos < 0) begin
      if (en) begin
        if (m_sent == MAXB) m_done = 1'b1;
        else start_frame();
      end
    end else if (m_pos == PL + m_len - 1) begin
      if (m_frames < 65535) m_frames++;
      if (m_sent == MAXB) begin m_done = 1'b1; m_pos = -1; end
      else if (!en) m_pos = -1;
      else m_pos++;
    end else if (!en) begin
      m_pos = -1;
    end else begin
      m_pos++;
      if (m_pos == PL + m_len + GL) start_frame();
      else if (m_pos >= PL && m_pos < PL + m_len) m_sent++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bit_en, abort);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bit_en = 1'b0; abort = 1'b0; bit_en0 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    if ({obs, obs0} !== 104'd0) begin
      errors++; $display("FAIL reset_values: dut=%h dut0=%h expected 0", obs, obs0);
    end
    checks++;
    do_reset();
  endtask

  task automatic test_full_run();
    logic [35:0] exp_s;
    int bad;
    exp_s = 36'b10101010101000_10101010101000_10101010;
    do_reset();
    bit_en = 1'b1; ncap = 0; nfs = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (obs !== model_out()) begin
        errors++; $display("FAIL full_run cycle %0d: dut=%h model=%h", n, obs, model_out());
      end
      checks++;
      if (tx_active === 1'b1) begin cap[ncap] = tx_bit_data; ncap++; end
      if (frame_start === 1'b1) nfs++;
    end
    bad = 0;
    for (int i = 0; i < 36; i++) begin
`ifdef TX_PRBS_EN
      if ((i % 14) >= PL && (i % 14) < PL + FB && cap[i] !== prbs_ref[(i % 14) - PL]) bad++;
`else
      if (cap[i] !== exp_s[35 - i]) bad++;
`endif
    end
    if (bad != 0 || ncap != 36) begin
      errors++; $display("FAIL full_run_stream: %0d wrong bits, %0d active bits, required 0 and 36", bad, ncap);
    end
    checks++;
    if ({done, bit_count, frame_count} !== {1'b1, 32'd20, 16'd3} || nfs != 3) begin
      errors++; $display("FAIL full_run_final: done=%b bc=%0d fc=%0d pulses=%0d required 1 20 3 3",
                         done, bit_count, frame_count, nfs);
    end
    checks++;
  endtask

  task automatic test_enable_drop();
    int guard;
    logic [11:0] exp_r;
    int bad;
    exp_r = 12'b1010_10101010;
    do_reset();
    bit_en = 1'b1; guard = 0;
    while (m_sent != 1 && guard < 30) begin
      tick(); guard++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL drop_run cycle %0d: dut=%h model=%h", guard, obs, model_out());
      end
      checks++;
    end
    if (guard >= 30) begin errors++; $display("FAIL drop_wait: timeout, bit_count=%0d required 1", bit_count); end
    checks++;
    bit_en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (obs !== model_out()) begin
        errors++; $display("FAIL drop_fall cycle %0d: dut=%h model=%h", n, obs, model_out());
      end
      checks++;
    end
    if ({tx_active, tx_bit_data, bit_count, frame_count} !== {1'b0, 1'b0, 32'd3, 16'd0}) begin
      errors++; $display("FAIL drop_idle: act=%b tx=%b bc=%0d fc=%0d required 0 0 3 0",
                         tx_active, tx_bit_data, bit_count, frame_count);
    end
    checks++;
    bit_en = 1'b1; ncap = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      if (obs !== model_out()) begin
        errors++; $display("FAIL drop_resume cycle %0d: dut=%h model=%h", n, obs, model_out());
      end
      checks++;
      if (tx_active === 1'b1 && ncap < 12) begin cap[ncap] = tx_bit_data; ncap++; end
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
`ifdef TX_PRBS_EN
      if (cap[i] !== tmpl_bit(i, FB)) bad++;
`else
      if (cap[i] !== exp_r[11 - i]) bad++;
`endif
    end
    if (bad != 0 || ncap != 12) begin
      errors++; $display("FAIL drop_resume_bits: %0d wrong of %0d captured, required 0 of 12", bad, ncap);
    end
    checks++;
  endtask

  task automatic test_abort();
    int guard;
    logic [35:0] exp_s;
    int bad;
    exp_s = 36'b10101010101000_10101010101000_10101010;
    do_reset();
    bit_en = 1'b1; guard = 0;
    while (!(m_frames == 1 && m_pos >= PL + m_len) && guard < 40) begin
      tick(); guard++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL abort_run cycle %0d: dut=%h model=%h", guard, obs, model_out());
      end
      checks++;
    end
    if (guard >= 40) begin errors++; $display("FAIL abort_wait: timeout, frame_count=%0d required 1", frame_count); end
    checks++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if ({tx_active, done, bit_count, frame_count} !== {1'b0, 1'b0, 32'd0, 16'd0}) begin
      errors++; $display("FAIL abort_clear: act=%b done=%b bc=%0d fc=%0d required 0 0 0 0",
                         tx_active, done, bit_count, frame_count);
    end
    checks++;
    ncap = 0;
    for (int n = 0; n < 45; n++) begin
      tick();
      if (obs !== model_out()) begin
        errors++; $display("FAIL abort_rerun cycle %0d: dut=%h model=%h", n, obs, model_out());
      end
      checks++;
      if (tx_active === 1'b1 && ncap < 64) begin cap[ncap] = tx_bit_data; ncap++; end
    end
    bad = 0;
    for (int i = 0; i < 36; i++) begin
`ifdef TX_PRBS_EN
      if ((i % 14) >= PL && (i % 14) < PL + FB && cap[i] !== prbs_ref[(i % 14) - PL]) bad++;
`else
      if (cap[i] !== exp_s[35 - i]) bad++;
`endif
    end
    if (bad != 0 || ncap != 36 || {done, bit_count, frame_count} !== {1'b1, 32'd20, 16'd3}) begin
      errors++; $display("FAIL abort_rerun_final: %0d wrong bits, %0d active, done=%b bc=%0d fc=%0d required 0 36 1 20 3",
                         bad, ncap, done, bit_count, frame_count);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset();
    bit_en = 1'b1; guard = 0;
    while (m_pos != PL + 3 && guard < 30) begin tick(); guard++; end
    if (guard >= 30 || tx_active !== 1'b1) begin
      errors++; $display("FAIL async_wait: timeout or inactive, act=%b required 1", tx_active);
    end
    checks++;
    #2 rst = 1'b1;
    #1;
    if (obs !== 52'd0) begin
      errors++; $display("FAIL async_reset: dut=%h required 0 before next edge", obs);
    end
    checks++;
    @(negedge clk);
    if (obs !== 52'd0) begin
      errors++; $display("FAIL async_reset_hold: dut=%h required 0", obs);
    end
    checks++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    hold = 0;
    for (int n = 0; n < 800; n++) begin
      if (hold == 0) begin
        bit_en = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 25);
      end
      hold--;
      abort = ($urandom_range(0, 39) == 0);
      tick();
      if (obs !== model_out()) begin
        errors++; $display("FAIL random cycle %0d: dut=%h model=%h", n, obs, model_out());
      end
      checks++;
    end
    abort = 1'b0;
  endtask

  task automatic test_max_zero();
    logic [51:0] exp0;
    do_reset();
    bit_en0 = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      exp0 = {3'b000, (n >= 3), 16'd0, 32'd0};
      if (obs0 !== exp0) begin
        errors++; $display("FAIL max_zero edge %0d: dut0=%h required %h", n, obs0, exp0);
      end
      checks++;
    end
    for (int n = 0; n < 12; n++) begin
      bit_en0 = 1'(($urandom_range(0, 1)));
      tick();
      if (obs0 !== {3'b000, 1'b1, 16'd0, 32'd0}) begin
        errors++; $display("FAIL max_zero_hold cycle %0d: dut0=%h required done only", n, obs0);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_enable_drop();
    test_abort();
    test_async_reset();
    test_random();
    test_max_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
